key_iv_loader: RTL
==================

KEY_IV_LOADER -- requirements
Module: key_iv_loader

Interface
REQ-001 SHALL have parameter TOTAL_BITS, default 160, giving the number of bits serialized per load (80 IV + 80 key).
REQ-002 SHALL have parameter WORD_W, default 8, giving the parallel input word width; TOTAL_BITS SHALL be an integer multiple of WORD_W.
REQ-003 SHALL have port clk_i, input, 1, the only clock; all state updates on its rising edge.
REQ-004 SHALL have port n_rst_i, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port ce_i, input, 1, chip enable; low stalls the serial shifting.
REQ-006 SHALL have port start_i, input, 1, a one-cycle request to begin a load sequence.
REQ-007 SHALL have port abort_i, input, 1, synchronous abort of the current sequence.
REQ-008 SHALL have port dat_i, input, WORD_W, the parallel word to serialize.
REQ-009 SHALL have port dat_valid_i, input, 1, meaning dat_i holds a valid word.
REQ-010 SHALL have port dat_ready_o, output, 1, meaning the block accepts dat_i this cycle.
REQ-011 SHALL have port ser_o, output, 1, the serial data bit, driving the downstream shift register data input.
REQ-012 SHALL have port ser_en_o, output, 1, the serial bit strobe, driving the downstream shift register chip enable.
REQ-013 SHALL have port busy_o, output, 1, high in every state except IDLE.
REQ-014 SHALL have port done_o, output, 1, a one-cycle pulse on completion.

Function
REQ-015 SHALL implement an FSM with states IDLE, LOAD, SHIFT and DONE.
REQ-016 IDLE: start_i=1 SHALL move the FSM to LOAD on the next edge and clear the bit and word counters.
REQ-017 LOAD: dat_ready_o SHALL be 1; the word SHALL be captured on dat_valid_i && dat_ready_o, with a transition to SHIFT.
REQ-018 dat_ready_o SHALL be 0 in IDLE, SHIFT and DONE; no word is captured outside LOAD.
REQ-019 SHIFT: ser_o SHALL equal bit 0 of the internal shift register, so words go out LSB first and in arrival order (IV words first, then key words, as supplied by the host).
REQ-020 SHIFT: ser_en_o SHALL equal ce_i combinationally; on each edge with ce_i=1, the shift register SHALL shift right by one and the bit counter SHALL increment.
REQ-021 SHIFT: with ce_i=0, no shift and no count SHALL occur; state SHALL be held indefinitely.
REQ-022 The first bit of a captured word SHALL appear on ser_o in the cycle immediately after the capture edge.
REQ-023 After WORD_W strobed bits, the FSM SHALL go to DONE if the word count has reached TOTAL_BITS/WORD_W, otherwise back to LOAD.
REQ-024 DONE SHALL last exactly one cycle with done_o=1, then return to IDLE.
REQ-025 ser_en_o SHALL be 0 in every state except SHIFT, so exactly TOTAL_BITS strobes occur per complete sequence.
REQ-026 start_i SHALL be ignored in LOAD, SHIFT and DONE.
REQ-027 abort_i=1 in any state SHALL force IDLE on the next edge and clear the counters, with no done_o pulse; abort_i SHALL take priority over start_i and over word capture.
REQ-028 The word counter SHALL be ceil(log2(TOTAL_BITS/WORD_W + 1)) bits wide and the bit counter ceil(log2(WORD_W + 1)) bits wide; neither SHALL wrap within a sequence.

Reset
REQ-029 n_rst_i=0 SHALL asynchronously force IDLE, clear the shift register and counters, and drive dat_ready_o=0, ser_o=0, ser_en_o=0, busy_o=0 and done_o=0.
REQ-030 A reset asserted mid-sequence SHALL discard the partial load; after release the block SHALL stay idle until a new start_i.

Verification
REQ-031 Full load: start_i, then 20 words 0x01..0x14 with dat_valid_i held high and ce_i=1 -> 160 strobes; ser_o bit stream equals 1,0,0,0,0,0,0,0,0,1,... LSB first; done_o pulses once; downstream register dat_o[159:152]=0x14 and dat_o[7:0]=0x01.
REQ-032 ce_i toggling 1,0,1,0 during SHIFT -> a strobe only in ce_i=1 cycles; bit order unchanged; total strobes still 160.
REQ-033 dat_valid_i gaps of 3 cycles between words -> dat_ready_o stays 1 through each gap; ser_en_o=0 during gaps; final data identical to REQ-031.
REQ-034 abort_i asserted after the 5th bit of word 3 -> IDLE next cycle, busy_o=0, no done_o; a new start_i restarts from word 0.
REQ-035 n_rst_i pulsed low mid-SHIFT -> all outputs 0 immediately (asynchronous); start_i asserted while busy -> no effect.

Source files
------------

// File: rtl/key_iv_loader.sv
// key_iv_loader: accepts TOTAL_BITS/WORD_W parallel words from a host and
// serializes them LSB first into a downstream shift register. Each word is
// sent as WORD_W data bits (ser_o), each paired with a strobe (ser_en_o).
//
// Handshake: a word on dat_i transfers on a rising edge where both
// dat_valid_i and dat_ready_o are 1. dat_ready_o depends only on state, so
// it never depends combinationally on dat_valid_i.
module key_iv_loader #(
    parameter int TOTAL_BITS = 160,
    parameter int WORD_W     = 8
) (
    input  logic              clk_i,
    input  logic              n_rst_i,
    input  logic              ce_i,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [WORD_W-1:0] dat_i,
    input  logic              dat_valid_i,
    output logic              dat_ready_o,
    output logic              ser_o,
    output logic              ser_en_o,
    output logic              busy_o,
    output logic              done_o,
    output logic [1:0]        dbg_state_o
);

    // TOTAL_BITS must be a whole number of words.
    localparam int NWORDS = TOTAL_BITS / WORD_W;
    localparam int WCW    = $clog2(NWORDS + 1);
    localparam int BCW    = $clog2(WORD_W + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_LOAD  = 2'd1;
    localparam logic [1:0] S_SHIFT = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [WCW-1:0] WCNT_LAST = WCW'(NWORDS);
    localparam logic [BCW-1:0] BCNT_LAST = BCW'(WORD_W - 1);

    logic [1:0]        state_q, state_d;
    logic [WORD_W-1:0] sreg_q,  sreg_d;
    logic [WCW-1:0]    wcnt_q,  wcnt_d;
    logic [BCW-1:0]    bcnt_q,  bcnt_d;

    // Next-state logic; abort overrides start and word capture.
    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        wcnt_d  = wcnt_q;
        bcnt_d  = bcnt_q;
        if (abort_i) begin
            state_d = S_IDLE;
            sreg_d  = '0;
            wcnt_d  = '0;
            bcnt_d  = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_d = S_LOAD;
                        wcnt_d  = '0;
                        bcnt_d  = '0;
                    end
                end
                S_LOAD: begin
                    if (dat_valid_i) begin
                        sreg_d  = dat_i;
                        wcnt_d  = wcnt_q + WCW'(1);
                        bcnt_d  = '0;
                        state_d = S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    // ce_i low freezes everything here, for as long as it stays low.
                    if (ce_i) begin
                        sreg_d = sreg_q >> 1;
                        bcnt_d = bcnt_q + BCW'(1);
                        if (bcnt_q == BCNT_LAST) begin
                            state_d = (wcnt_q == WCNT_LAST) ? S_DONE : S_LOAD;
                        end
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            state_q <= S_IDLE;
            sreg_q  <= '0;
            wcnt_q  <= '0;
            bcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            wcnt_q  <= wcnt_d;
            bcnt_q  <= bcnt_d;
        end
    end

    // Outputs decoded from state; the strobe follows ce_i only while shifting.
    always_comb begin
        dat_ready_o = (state_q == S_LOAD);
        ser_en_o    = (state_q == S_SHIFT) && ce_i;
        ser_o       = (state_q == S_SHIFT) && sreg_q[0];
        busy_o      = (state_q != S_IDLE);
        done_o      = (state_q == S_DONE);
        dbg_state_o = state_q;
    end

endmodule
